axis_rx_checker: RTL and testbench

Receive-side traffic checker for the 10G UDP loopback bench and board bring-up. It sinks the user AXI-Stream output of the UDP stack, which has no `tready`, and verifies each frame against the pattern our AXIS test generator produces: incrementing bytes, a per-frame sequence seed, and the byte length carried in `tuser`. It reports per-frame verdicts, saturating good and bad frame counters, and a sticky error flag.

---
 rtl/axis_rx_chk_pkg.sv | 48 ++++
 rtl/axis_keep_decode.sv | 14 +
 rtl/axis_rx_checker.sv | 136 +++++++++++++
 tb/tb_axis_rx_checker.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rx_chk_pkg.sv
// Shared types and helpers for the AXIS receive checker: error bit indices,
// FSM state, beat/verdict structs and keep decoding functions.
package axis_rx_chk_pkg;

  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;

  localparam int ERR_DATA = 0;
  localparam int ERR_LEN  = 1;
  localparam int ERR_KEEP = 2;
  localparam int ERR_SEQ  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] data;
    logic [15:0]                     len;
    logic [NUM_LANES-1:0]            keep;
    logic                            last;
  } beat_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] err;
  } verdict_t;

  function automatic logic [3:0] keep_popcount(input logic [7:0] k);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, k[i]};
    return c;
  endfunction

  // Last beat may only drop trailing bytes: keep is a run of ones from the MSB.
  function automatic logic keep_last_legal(input logic [7:0] k);
    logic ok;
    case (k)
      8'hFF, 8'hFE, 8'hFC, 8'hF8,
      8'hF0, 8'hE0, 8'hC0, 8'h80: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axis_keep_decode.sv
// Combinational keep decoder: byte count and legality of a beat's keep mask.
module axis_keep_decode
  import axis_rx_chk_pkg::*;
(
  input  logic [7:0] keep,
  input  logic       last,
  output logic [3:0] cnt,
  output logic       legal
);

  assign cnt   = keep_popcount(keep);
  assign legal = last ? keep_last_legal(keep) : (keep == 8'hFF);

endmodule

// File: rtl/axis_rx_checker.sv
// Receive-side traffic checker: verifies incrementing-byte frames with a
// per-frame seed and tuser length, reports verdicts and saturating counters.
module axis_rx_checker
  import axis_rx_chk_pkg::*;
#(
  parameter logic [7:0]  P_START_SEQ = 8'd0,
  parameter logic [15:0] P_MAX_LEN   = 16'd1472,
  parameter bit          P_CHECK_SEQ = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] s_axis_tdata,
  input  logic [31:0] s_axis_tuser,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  input  logic        i_clr,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [3:0]  o_err_type,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_bad_cnt,
  output logic        o_err_flag
);

  localparam int STAGES = 1;

  state_t      st;
  logic [7:0]  seed_r, base_r, exp_seed;
  logic [15:0] len_r, acc_r;
  logic [3:0]  err_r;
  logic [STAGES:1] vld_pipe;

  beat_t       bt;
  logic        first, done, len_bad_last;
  logic [7:0]  cur_seed, cur_base;
  logic [15:0] cur_len, cur_acc, acc_sum;
  logic [16:0] acc_wide;
  logic [3:0]  kcnt;
  logic        klegal;
  logic [NUM_LANES-1:0] lane_bad;
  logic [3:0]  err_beat, err_next;
  logic        unused_tuser;

  assign bt.data = s_axis_tdata;
  assign bt.len  = s_axis_tuser[31:16];
  assign bt.keep = s_axis_tkeep;
  assign bt.last = s_axis_tlast;
  assign unused_tuser = ^s_axis_tuser[15:0];

  assign first    = (st == IDLE);
  assign done     = s_axis_tvalid && bt.last;
  assign cur_seed = first ? bt.data[NUM_LANES-1] : seed_r;
  assign cur_base = first ? bt.data[NUM_LANES-1] : base_r;
  assign cur_len  = first ? bt.len : len_r;
  assign cur_acc  = first ? 16'd0 : acc_r;

  axis_keep_decode u_keep (
    .keep  (bt.keep),
    .last  (bt.last),
    .cnt   (kcnt),
    .legal (klegal)
  );

  // Byte j sits in the most-significant lane first, hence the reversed index.
  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    logic [VEC_W-1:0] exp_b;
    assign exp_b       = cur_base + VEC_W'(j);
    assign lane_bad[j] = bt.keep[NUM_LANES-1-j] && (bt.data[NUM_LANES-1-j] != exp_b);
  end

  assign acc_wide = {1'b0, cur_acc} + {13'd0, kcnt};
  assign acc_sum  = acc_wide[16] ? 16'hFFFF : acc_wide[15:0];

  assign len_bad_last = (acc_sum != cur_len) || (cur_len == 16'd0) || (cur_len > P_MAX_LEN);

  always_comb begin
    err_beat           = '0;
    err_beat[ERR_DATA] = |lane_bad;
    err_beat[ERR_LEN]  = (!first && (bt.len != len_r)) || (bt.last && len_bad_last);
    err_beat[ERR_KEEP] = !klegal;
    err_beat[ERR_SEQ]  = P_CHECK_SEQ && first && (bt.data[NUM_LANES-1] != exp_seed);
    err_next           = (first ? 4'b0000 : err_r) | err_beat;
  end

  assign o_frame_done = vld_pipe[STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st         <= IDLE;
      seed_r     <= '0;
      base_r     <= '0;
      len_r      <= '0;
      acc_r      <= '0;
      err_r      <= '0;
      exp_seed   <= P_START_SEQ;
      vld_pipe   <= '0;
      o_frame_ok <= 1'b0;
      o_err_type <= '0;
      o_good_cnt <= '0;
      o_bad_cnt  <= '0;
      o_err_flag <= 1'b0;
    end else begin
      for (int s = STAGES; s > 1; s--) vld_pipe[s] <= vld_pipe[s-1];
      vld_pipe[1] <= done;
      o_frame_ok  <= done && (err_next == 4'b0000);
      o_err_type  <= done ? err_next : 4'b0000;

      if (s_axis_tvalid) begin
        seed_r <= cur_seed;
        base_r <= cur_base + 8'(NUM_LANES);
        len_r  <= cur_len;
        acc_r  <= acc_sum;
        err_r  <= err_next;
        st     <= bt.last ? IDLE : DATA;
      end

      // Clear wins over a completion landing in the same cycle.
      if (i_clr) begin
        exp_seed   <= P_START_SEQ;
        o_good_cnt <= '0;
        o_bad_cnt  <= '0;
        o_err_flag <= 1'b0;
      end else if (done) begin
        exp_seed <= cur_seed + 8'd1;
        if (err_next == 4'b0000) begin
          if (o_good_cnt != 32'hFFFF_FFFF) o_good_cnt <= o_good_cnt + 32'd1;
        end else begin
          if (o_bad_cnt != 32'hFFFF_FFFF) o_bad_cnt <= o_bad_cnt + 32'd1;
          o_err_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_rx_checker.sv
// Randomized and directed bench for axis_rx_checker with a frame-level model.
module tb_axis_rx_checker;

  localparam logic [7:0] START = 8'd0;
  localparam int         MAXL  = 1472;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] tdata = '0;
  logic [31:0] tuser = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        clr = 1'b0;
  logic        o_done, o_ok, o_flag;
  logic [3:0]  o_err;
  logic [31:0] o_good, o_bad;

  always #5 clk = ~clk;

  axis_rx_checker #(
    .P_START_SEQ (START),
    .P_MAX_LEN   (16'd1472),
    .P_CHECK_SEQ (1'b1)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tuser  (tuser),
    .s_axis_tkeep  (tkeep),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid),
    .i_clr         (clr),
    .o_frame_done  (o_done),
    .o_frame_ok    (o_ok),
    .o_err_type    (o_err),
    .o_good_cnt    (o_good),
    .o_bad_cnt     (o_bad),
    .o_err_flag    (o_flag)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [63:0] f_data[$];
  logic [7:0]  f_keep[$];
  logic [15:0] f_len[$];
  logic [7:0]  m_exp_seed;
  logic        m_done, m_ok, m_flag;
  logic [3:0]  m_err;
  logic [31:0] m_good, m_bad;
  logic [3:0]  mdl_err[$];

  function automatic logic [3:0] frame_err();
    logic [3:0]  e;
    logic [7:0]  seed, ev;
    logic [15:0] L;
    int          total, nb;
    e = '0; total = 0; nb = f_data.size();
    seed = f_data[0][63:56];
    L = f_len[0];
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++) begin
        ev = seed + 8'(8 * b + j);
        if (f_keep[b][7-j] && (f_data[b][63-8*j -: 8] != ev)) e[0] = 1'b1;
      end
      total += $countones(f_keep[b]);
      if (f_len[b] != L) e[1] = 1'b1;
      if (b < nb - 1) begin
        if (f_keep[b] != 8'hFF) e[2] = 1'b1;
      end else if (!(f_keep[b] inside {8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80})) begin
        e[2] = 1'b1;
      end
    end
    if (total > 65535) total = 65535;
    if (total != int'(L) || L == 16'd0 || int'(L) > MAXL) e[1] = 1'b1;
    if (seed != m_exp_seed) e[3] = 1'b1;
    return e;
  endfunction

  initial begin
    m_exp_seed = START; m_done = 0; m_ok = 0; m_err = 0;
    m_good = 0; m_bad = 0; m_flag = 0;
    forever begin
      @(posedge clk);
      m_done = 1'b0; m_ok = 1'b0; m_err = '0;
      if (!rst_n) begin
        f_data.delete(); f_keep.delete(); f_len.delete();
        m_exp_seed = START; m_good = 0; m_bad = 0; m_flag = 0;
      end else begin
        if (tvalid) begin
          f_data.push_back(tdata); f_keep.push_back(tkeep); f_len.push_back(tuser[31:16]);
          if (tlast) begin
            m_err = frame_err();
            m_ok = (m_err == 4'b0000);
            m_done = 1'b1;
            m_exp_seed = f_data[0][63:56] + 8'd1;
            mdl_err.push_back(m_err);
            f_data.delete(); f_keep.delete(); f_len.delete();
          end
        end
        if (clr) begin
          m_good = 0; m_bad = 0; m_flag = 0; m_exp_seed = START;
        end else if (m_done) begin
          if (m_ok) begin
            if (m_good != 32'hFFFF_FFFF) m_good = m_good + 1;
          end else begin
            if (m_bad != 32'hFFFF_FFFF) m_bad = m_bad + 1;
            m_flag = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [3:0] obs_err[$];
  logic       obs_ok[$];

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("frame_done", o_done, m_done);
      if (m_done) begin
        check("frame_ok", o_ok, m_ok);
        check("err_type", o_err, m_err);
      end
      check("good_cnt", o_good, m_good);
      check("bad_cnt", o_bad, m_bad);
      check("err_flag", o_flag, m_flag);
    end
    if (o_done === 1'b1) begin
      obs_err.push_back(o_err);
      obs_ok.push_back(o_ok);
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] b_data[256];
  logic [7:0]  b_keep[256];
  logic [15:0] b_len[256];
  int          b_n;

  task automatic build(input logic [7:0] seed, input int L);
    int rem;
    b_n = (L + 7) / 8;
    if (b_n < 1) b_n = 1;
    for (int b = 0; b < b_n; b++) begin
      for (int j = 0; j < 8; j++) b_data[b][63-8*j -: 8] = seed + 8'(8 * b + j);
      b_keep[b] = 8'hFF;
      b_len[b] = 16'(L);
    end
    rem = L - 8 * (b_n - 1);
    if (rem >= 1 && rem <= 8) b_keep[b_n-1] = ~(8'hFF >> rem);
  endtask

  task automatic idle_cycle();
    tvalid = 1'b0;
    tdata = {$urandom, $urandom};
    tkeep = 8'($urandom);
    tlast = 1'($urandom);
    tuser = $urandom;
    @(posedge clk); #1;
    tlast = 1'b0;
  endtask

  task automatic drive(input int gap_pct, input bit clr_last, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      while (int'($urandom_range(99)) < gap_pct) idle_cycle();
      tdata = b_data[b]; tkeep = b_keep[b];
      tuser = {b_len[b], 16'($urandom)};
      tlast = (b == b_n - 1);
      tvalid = 1'b1;
      clr = clr_last && (b == b_n - 1);
      @(posedge clk); #1;
      tvalid = 1'b0; tlast = 1'b0; clr = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] seed, input int L, input int gap_pct);
    build(seed, L);
    drive(gap_pct, 1'b0, b_n);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic lit_cnt(input string name, input int g, input int bd, input bit fl);
    check({name, "_good"}, o_good, 64'(g));
    check({name, "_bad"}, o_bad, 64'(bd));
    check({name, "_flag"}, o_flag, 64'(fl));
    check({name, "_model_good"}, m_good, 64'(g));
    check({name, "_model_bad"}, m_bad, 64'(bd));
  endtask

  task automatic lit_err(input string name, input int idx, input logic [3:0] e);
    check({name, "_err"}, obs_err[idx], 64'(e));
    check({name, "_ok"}, obs_ok[idx], 64'(e == 4'b0000));
    check({name, "_model_err"}, mdl_err[idx], 64'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, L;
    logic [7:0] sd;
    rst_n = 1'b0;
    wait_cycles(2);
    chk_en = 1'b1;
    wait_cycles(1);
    check("rst_done", o_done, 0);
    check("rst_ok", o_ok, 0);
    check("rst_err", o_err, 0);
    lit_cnt("rst", 0, 0, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // single 20-byte frame, keep FF FF F0
    base = obs_err.size();
    send(8'h00, 20, 0);
    wait_cycles(3);
    check("single_keep_last", b_keep[2], 8'hF0);
    check("single_ndone", obs_err.size() - base, 1);
    lit_err("single", base, 4'b0000);
    lit_cnt("single", 1, 0, 0);

    // 100 gapped frames
    clr_pulse();
    for (int i = 0; i < 100; i++) send(8'(i), 64, 30);
    wait_cycles(3);
    lit_cnt("b2b", 100, 0, 0);

    // corrupted byte 9 of seed-5 frame
    clr_pulse();
    base = obs_err.size();
    for (int i = 0; i < 5; i++) send(8'(i), 24, 0);
    build(8'h05, 20);
    b_data[1][55:48] = 8'hAA;
    drive(0, 1'b0, b_n);
    send(8'h06, 20, 0);
    wait_cycles(3);
    lit_err("corrupt", base + 5, 4'b0001);
    lit_err("resync", base + 6, 4'b0000);
    lit_cnt("corrupt", 6, 1, 1);

    // length and keep errors, max-length boundary
    clr_pulse();
    base = obs_err.size();
    build(8'h00, 20); b_keep[2] = 8'hFF; drive(0, 1'b0, b_n);
    build(8'h01, 4);  b_keep[0] = 8'h0F; drive(0, 1'b0, b_n);
    send(8'h02, 1500, 0);
    send(8'h03, 1472, 0);
    send(8'h04, 1473, 0);
    wait_cycles(3);
    lit_err("len_keepff", base, 4'b0010);
    lit_err("keep_0f", base + 1, 4'b0100);
    lit_err("len_1500", base + 2, 4'b0010);
    lit_err("len_max", base + 3, 4'b0000);
    lit_err("len_max1", base + 4, 4'b0010);

    // sequence error
    clr_pulse();
    base = obs_err.size();
    send(8'h00, 16, 0); send(8'h01, 16, 0); send(8'h05, 16, 0); send(8'h06, 16, 0);
    wait_cycles(3);
    lit_err("seq0", base, 4'b0000);
    lit_err("seq2", base + 2, 4'b1000);
    lit_err("seq3", base + 3, 4'b0000);
    lit_cnt("seq", 3, 1, 1);

    // clear coinciding with completion
    base = obs_err.size();
    build(8'h07, 16);
    drive(0, 1'b1, b_n);
    wait_cycles(2);
    check("clr_done_pulsed", obs_err.size() - base, 1);
    lit_cnt("clr_same", 0, 0, 0);
    send(START, 16, 0);
    wait_cycles(3);
    lit_cnt("after_clr", 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      sd = ($urandom_range(3) == 0) ? 8'($urandom) : m_exp_seed;
      L = int'($urandom_range(1, 120));
      if ($urandom_range(15) == 0) L = 0;
      if ($urandom_range(15) == 0) L = MAXL + int'($urandom_range(0, 1));
      build(sd, L);
      if ($urandom_range(5) == 0) b_data[$urandom_range(b_n-1)][8*$urandom_range(7) +: 8] ^= 8'(1 + $urandom_range(254));
      if ($urandom_range(7) == 0) b_keep[b_n-1] = 8'($urandom);
      if (b_n > 1 && $urandom_range(7) == 0) b_keep[$urandom_range(b_n-2)] = 8'($urandom);
      if (b_n > 1 && $urandom_range(9) == 0) b_len[b_n-1] = b_len[b_n-1] ^ 16'h0004;
      drive(($urandom_range(1) == 0) ? 0 : 30, ($urandom_range(7) == 0), b_n);
      if ($urandom_range(9) == 0) clr_pulse();
    end
    wait_cycles(3);

    // reset in the middle of a frame
    build(m_exp_seed, 32);
    drive(0, 1'b0, 2);
    rst_n = 1'b0;
    wait_cycles(3);
    check("mrst_done", o_done, 0);
    check("mrst_ok", o_ok, 0);
    check("mrst_err", o_err, 0);
    lit_cnt("mrst", 0, 0, 0);
    rst_n = 1'b1;
    wait_cycles(1);
    base = obs_err.size();
    send(START, 32, 20);
    wait_cycles(3);
    lit_err("post_rst", base, 4'b0000);
    lit_cnt("post_rst", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
